// File: rtl/ppu_frame_sequencer.sv
// Aligns the PPU pixel stream to the HDMI frame trigger and writes pixels into a
// ping-pong line buffer, flagging timing violations and tracking lock.
module ppu_frame_sequencer #(
  parameter int ISCREEN_WIDTH  = 256,
  parameter int ISCREEN_HEIGHT = 240,
  parameter int IPIXEL_LATENCY = 4,
  parameter int LOCK_FRAMES    = 4
) (
  input  logic       clk_p,
  input  logic       rst_p,
  input  logic       new_frame,
  input  logic       pix_valid,
  input  logic [5:0] pix_data,
  output logic       buf_we,
  output logic [8:0] buf_addr,
  output logic [5:0] buf_wdata,
  output logic       line_ready,
  output logic       line_bank,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {ST_WAIT, ST_ARM, ST_ACTIVE} state_t;

  localparam logic [7:0] X_LAST   = 8'(ISCREEN_WIDTH - 1);
  localparam logic [7:0] Y_LAST   = 8'(ISCREEN_HEIGHT - 1);
  localparam logic [3:0] ARM_LAST = 4'(IPIXEL_LATENCY - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       bank_q, bank_d;
  logic [3:0] clean_q, clean_d;
  logic       we_q, we_d;
  logic [8:0] addr_q, addr_d;
  logic [5:0] wdata_q, wdata_d;
  logic       lr_q, lr_d;
  logic       lb_q, lb_d;
  logic       fs_q, fs_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       wr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    bank_d    = bank_q;
    clean_d   = clean_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lr_d      = 1'b0;
    lb_d      = 1'b0;
    fs_d      = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    wr        = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (new_frame) begin
          state_d = ST_ARM;
          cnt_d   = 4'd0;
        end
      end
      ST_ARM: begin
        if (new_frame) begin
          err_d = 1'b1;
          cnt_d = 4'd0;
        end else if (pix_valid) begin
          if (cnt_q == ARM_LAST) begin
            wr      = 1'b1;
            fs_d    = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (cnt_q == ARM_LAST) begin
          err_d   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACTIVE: begin
        // A trigger mid-frame drops the partial line and re-arms immediately.
        if (new_frame) begin
          err_d   = 1'b1;
          x_d     = 8'd0;
          y_d     = 8'd0;
          cnt_d   = 4'd0;
          state_d = ST_ARM;
        end else if (pix_valid) begin
          wr = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (wr) begin
      we_d    = 1'b1;
      addr_d  = {bank_q, x_q};
      wdata_d = pix_data;
      if (x_q == X_LAST) begin
        x_d    = 8'd0;
        lr_d   = 1'b1;
        lb_d   = bank_q;
        bank_d = ~bank_q;
        if (y_q == Y_LAST) begin
          y_d     = 8'd0;
          clean_d = (clean_q == LOCK_N) ? clean_q : clean_q + 4'd1;
          state_d = ST_WAIT;
        end else begin
          y_d = y_q + 8'd1;
        end
      end else begin
        x_d = x_q + 8'd1;
      end
    end

    if (err_d) begin
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      clean_d   = 4'd0;
    end

    // Registered from clean_q so lock rises a cycle after the last line, but an
    // error clears it in the same cycle as sync_err.
    locked_d = err_d ? 1'b0 : (clean_q == LOCK_N);
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q   <= ST_WAIT;
      cnt_q     <= 4'd0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      bank_q    <= 1'b0;
      clean_q   <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 9'd0;
      wdata_q   <= 6'd0;
      lr_q      <= 1'b0;
      lb_q      <= 1'b0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bank_q    <= bank_d;
      clean_q   <= clean_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lr_q      <= lr_d;
      lb_q      <= lb_d;
      fs_q      <= fs_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign buf_we      = we_q;
  assign buf_addr    = addr_q;
  assign buf_wdata   = wdata_q;
  assign line_ready  = lr_q;
  assign line_bank   = lb_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign sync_err    = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ppu_frame_sequencer.sv
// Scoreboard bench for ppu_frame_sequencer on a reduced 8x6 frame: stimulus
// queues expected writes/errors with their cycle, a negedge monitor checks them.
module tb_ppu_frame_sequencer;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int LAT  = 4;
  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst_p, new_frame, pix_valid;
  logic [5:0] pix_data;
  logic       buf_we, line_ready, line_bank, frame_start, locked, sync_err;
  logic [8:0] buf_addr;
  logic [5:0] buf_wdata;
  logic [7:0] err_cnt;

  ppu_frame_sequencer #(
    .ISCREEN_WIDTH(W), .ISCREEN_HEIGHT(H), .IPIXEL_LATENCY(LAT), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk_p(clk), .rst_p(rst_p), .new_frame(new_frame), .pix_valid(pix_valid),
    .pix_data(pix_data), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .line_ready(line_ready), .line_bank(line_bank), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [5:0] data;
    logic       lr;
    logic       lb;
    logic       fs;
  } wr_t;
  typedef struct {
    int cyc;
    int cnt;
  } er_t;

  wr_t wq[$];
  er_t eq[$];

  int   errors = 0;
  int   checks = 0;
  int   lr_seen = 0;
  bit   mon_en = 1'b0;
  int   exp_err = 0;
  int   m_x = 0, m_y = 0;
  logic m_bank = 1'b0;
  int   seed = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    er_t r;
    if (mon_en) begin
      if (buf_we) begin
        if (wq.size() == 0) begin
          check("write_unexpected", int'(buf_addr), -1);
        end else begin
          e = wq.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", int'(buf_addr), int'(e.addr));
          check("wr_data", int'(buf_wdata), int'(e.data));
          check("line_ready", int'(line_ready), int'(e.lr));
          if (e.lr) check("line_bank", int'(line_bank), int'(e.lb));
          check("frame_start", int'(frame_start), int'(e.fs));
        end
        if (line_ready) lr_seen++;
      end else if (line_ready || frame_start) begin
        check("pulse_without_write", int'(line_ready) + int'(frame_start), 0);
      end
      if (sync_err) begin
        if (eq.size() == 0) begin
          check("sync_err_unexpected", cyc, -1);
        end else begin
          r = eq.pop_front();
          check("err_cycle", cyc, r.cyc);
          check("err_cnt_at_err", int'(err_cnt), r.cnt);
        end
      end
    end
  end

  task automatic tick(input logic nf, input logic pv, input logic [5:0] pd);
    new_frame = nf;
    pix_valid = pv;
    pix_data  = pd;
    @(posedge clk);
    #1;
    new_frame = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic push_err(input int c);
    er_t r;
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    r.cyc = c;
    r.cnt = exp_err;
    eq.push_back(r);
  endtask

  // new_frame followed by the idle cycles before the first pixel slot.
  task automatic trigger(input bit err_exp, input logic pv);
    if (err_exp) push_err(cyc + 1);
    m_x = 0;
    m_y = 0;
    tick(1'b1, pv, 6'h3F);
    repeat (LAT - 1) tick(1'b0, 1'b0, 6'd0);
  endtask

  task automatic pixel(input logic first);
    wr_t        w;
    logic [5:0] pd;
    pd     = 6'(seed * 13 + 5);
    seed++;
    w.cyc  = cyc + 1;
    w.addr = {m_bank, 8'(m_x)};
    w.data = pd;
    w.lr   = (m_x == W - 1);
    w.lb   = m_bank;
    w.fs   = first;
    wq.push_back(w);
    if (m_x == W - 1) begin
      m_x    = 0;
      m_bank = ~m_bank;
      m_y    = (m_y == H - 1) ? 0 : m_y + 1;
    end else begin
      m_x++;
    end
    tick(1'b0, 1'b1, pd);
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pixel(i == 0);
      if (i % 7 == 3) tick(1'b0, 1'b0, 6'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_buf_we"}, int'(buf_we), 0);
    check({tag, "_buf_addr"}, int'(buf_addr), 0);
    check({tag, "_buf_wdata"}, int'(buf_wdata), 0);
    check({tag, "_line_ready"}, int'(line_ready), 0);
    check({tag, "_line_bank"}, int'(line_bank), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_sync_err"}, int'(sync_err), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lr0;
    int t;
    rst_p = 1'b1; new_frame = 1'b0; pix_valid = 1'b0; pix_data = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_p  = 1'b0;
    mon_en = 1'b1;

    // Stray pixels before any trigger are ignored.
    tick(1'b0, 1'b1, 6'd9);
    tick(1'b0, 1'b1, 6'd10);

    for (int f = 0; f < LOCK; f++) begin
      lr0 = lr_seen;
      trigger(1'b0, 1'b0);
      pixels(W * H);
      check("locked_before_rise", int'(locked), 0);
      tick(1'b0, 1'b0, 6'd0);
      check("lines_per_frame", lr_seen - lr0, H);
      check("locked_after_frame", int'(locked), (f == LOCK - 1) ? 1 : 0);
      check("err_cnt_clean", int'(err_cnt), 0);
    end

    // Late first pixel: error after the missed slot, lock drops with it.
    t = cyc;
    tick(1'b1, 1'b0, 6'd0);
    repeat (LAT - 1) tick(1'b0, 1'b0, 6'd0);
    check("locked_held", int'(locked), 1);
    push_err(t + LAT + 1);
    tick(1'b0, 1'b0, 6'd0);
    check("locked_dropped", int'(locked), 0);
    tick(1'b0, 1'b1, 6'd21);
    tick(1'b0, 1'b0, 6'd0);

    // Short frame (4 lines + 5 pixels), interrupted with a coincident pixel.
    lr0 = lr_seen;
    trigger(1'b0, 1'b0);
    pixels(W * 4 + 5);
    trigger(1'b1, 1'b1);
    check("short_frame_lines", lr_seen - lr0, 4);
    pixels(W * H);
    tick(1'b0, 1'b0, 6'd0);

    // Early pixel at t+2, then a correctly timed frame.
    tick(1'b1, 1'b0, 6'd0);
    tick(1'b0, 1'b0, 6'd0);
    push_err(cyc + 1);
    tick(1'b0, 1'b1, 6'd33);
    tick(1'b0, 1'b0, 6'd0);
    check("err_cnt_early", int'(err_cnt), exp_err);
    trigger(1'b0, 1'b0);
    pixels(W * H);
    tick(1'b0, 1'b0, 6'd0);

    // Second trigger while armed re-arms from zero.
    tick(1'b1, 1'b0, 6'd0);
    tick(1'b0, 1'b0, 6'd0);
    trigger(1'b1, 1'b0);
    pixels(W * H);
    tick(1'b0, 1'b0, 6'd0);

    // Saturate the error counter with early pixels.
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, 6'd0);
      push_err(cyc + 1);
      tick(1'b0, 1'b1, 6'd1);
    end
    tick(1'b0, 1'b0, 6'd0);
    check("err_cnt_saturated", int'(err_cnt), 255);

    // Reset mid-ACTIVE with a pixel presented in the reset cycle.
    trigger(1'b0, 1'b0);
    pixels(10);
    rst_p     = 1'b1;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    rst_p     = 1'b0;
    pix_valid = 1'b0;
    m_bank    = 1'b0;
    exp_err   = 0;

    // Frame after reset restarts at bank 0, x 0.
    lr0 = lr_seen;
    trigger(1'b0, 1'b0);
    pixels(W * H);
    repeat (2) tick(1'b0, 1'b0, 6'd0);
    check("lines_after_reset", lr_seen - lr0, H);
    check("writes_outstanding", wq.size(), 0);
    check("errors_outstanding", eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
